// File: rtl/keypad_scan_entry.sv
// 4x4 active-low keypad scanner with debounce.
// Emits one digit or function-key strobe per accepted press.
module keypad_scan_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [3:0] keycode,
  output logic [3:0] digit,
  output logic       digit_strobe,
  output logic       fn_strobe,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB       = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  // nibble at {row,col}: r0 1 2 3 A, r1 4 5 6 B, r2 7 8 9 C, r3 E 0 F D
  localparam logic [63:0] KMAP =
    {16'hDF0E, 16'hC987, 16'hB654, 16'hA321};

  typedef enum logic [1:0] {
    IDLE, PRESS, HELD, RELEASE
  } state_t;

  function automatic logic [3:0] key_at(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return KMAP[{r, c, 2'b00} +: 4];
  endfunction

  logic [3:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col;
  logic [3:0]    r_col_drive;
  logic [1:0]    r_acc_cnt;
  logic [3:0]    r_acc_code;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic [3:0]    r_keycode, r_digit;
  logic          r_dstb, r_fstb;

  logic          w_sample, w_done;
  logic [3:0]    w_hit;
  logic [2:0]    w_col_n, w_tot;
  logic [3:0]    w_col_code, w_code;
  logic          w_one, w_multi;
  state_t        w_nxt;
  logic [CW-1:0] w_cnt_n;
  logic [3:0]    w_cand_n;
  logic          w_acc;

  assign w_sample = (r_div == DIV_LAST);
  assign w_done   = w_sample && (r_col == 2'd3);
  assign w_hit    = ~r_sync2;

  always_comb begin
    w_col_n    = 3'd0;
    w_col_code = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_hit[i]) begin
        w_col_n    = w_col_n + 3'd1;
        w_col_code = key_at(2'(i), r_col);
      end
    end
  end

  assign w_tot   = {1'b0, r_acc_cnt} + w_col_n;
  assign w_multi = (w_tot >= 3'd2);
  assign w_one   = (w_tot == 3'd1);
  assign w_code  = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;

  always_comb begin
    w_nxt    = r_state;
    w_cnt_n  = r_cnt;
    w_cand_n = r_cand;
    w_acc    = 1'b0;
    if (w_done) begin
      unique case (r_state)
        IDLE: begin
          if (w_one) begin
            w_cand_n = w_code;
            w_cnt_n  = ONE_CNT;
            if (DB == ONE_CNT) begin
              w_acc = 1'b1;
              w_nxt = HELD;
            end else begin
              w_nxt = PRESS;
            end
          end
        end
        PRESS: begin
          if (w_multi) begin
            w_cnt_n = ONE_CNT;
          end else if (!w_one) begin
            w_nxt = IDLE;
          end else if (w_code != r_cand) begin
            w_cand_n = w_code;
            w_cnt_n  = ONE_CNT;
            if (DB == ONE_CNT) begin
              w_acc = 1'b1;
              w_nxt = HELD;
            end
          end else if (r_cnt + ONE_CNT == DB) begin
            w_acc = 1'b1;
            w_nxt = HELD;
          end else begin
            w_cnt_n = r_cnt + ONE_CNT;
          end
        end
        HELD: begin
          if (!w_one && !w_multi) begin
            w_cnt_n = ONE_CNT;
            w_nxt   = (DB == ONE_CNT) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (w_one || w_multi) begin
            w_nxt = HELD;
          end else if (r_cnt + ONE_CNT == DB) begin
            w_nxt = IDLE;
          end else begin
            w_cnt_n = r_cnt + ONE_CNT;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1     <= 4'b1111;
      r_sync2     <= 4'b1111;
      r_div       <= '0;
      r_col       <= 2'd0;
      r_col_drive <= 4'b1110;
      r_acc_cnt   <= 2'd0;
      r_acc_code  <= 4'd0;
    end else begin
      r_sync1 <= row_sense;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        r_div       <= '0;
        r_col       <= r_col + 2'd1;
        r_col_drive <= {r_col_drive[2:0], r_col_drive[3]};
        if (r_col == 2'd3) begin
          r_acc_cnt  <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_cnt  <= w_multi ? 2'd2 : w_tot[1:0];
          r_acc_code <= w_code;
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cand    <= 4'd0;
      r_keycode <= 4'd0;
      r_digit   <= 4'd0;
      r_dstb    <= 1'b0;
      r_fstb    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_n;
      r_cand  <= w_cand_n;
      r_dstb  <= w_acc && (w_cand_n <= 4'd9);
      r_fstb  <= w_acc && (w_cand_n > 4'd9);
      if (w_acc) begin
        r_keycode <= w_cand_n;
        if (w_cand_n <= 4'd9) r_digit <= w_cand_n;
      end
    end
  end

  assign col_drive    = r_col_drive;
  assign keycode      = r_keycode;
  assign digit        = r_digit;
  assign digit_strobe = r_dstb;
  assign fn_strobe    = r_fstb;
  assign key_held     = (r_state == HELD) || (r_state == RELEASE);

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Bench for keypad_scan_entry: physical keypad stub,
// scan-level reference model and directed key scenarios.
module tb_keypad_scan_entry;
  localparam int SD = 4;
  localparam int DB = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] pressed = 16'h0;
  logic [3:0]  row_sense, col_drive, keycode, digit;
  logic        digit_strobe, fn_strobe, key_held;

  int n_pass = 0;
  int n_chk  = 0;
  int n_ds   = 0;
  int n_fs   = 0;

  keypad_scan_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .CLK(CLK), .RST(RST), .row_sense(row_sense),
    .col_drive(col_drive), .keycode(keycode), .digit(digit),
    .digit_strobe(digit_strobe), .fn_strobe(fn_strobe),
    .key_held(key_held)
  );

  always #5 CLK = ~CLK;

  // keypad: a pressed key shorts its row to the driven (low) column
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_drive[c]) row_sense[r] = 1'b0;
  end

  int KM[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  logic [3:0] m_s1, m_s2, m_rw;
  int m_div, m_col, m_hits, m_code, m_st, m_cnt, m_cand;
  int e_key, e_dig;
  bit e_ds, e_fs, e_held;

  task automatic accept();
    e_key = m_cand;
    if (m_cand <= 9) begin e_dig = m_cand; e_ds = 1; end
    else e_fs = 1;
    m_st = 2;
    e_held = 1;
  endtask

  // kind: 0 none, 1 single key, 2 several keys
  task automatic debounce(input int kind, input int code);
    case (m_st)
      0: if (kind == 1) begin
        m_cand = code; m_cnt = 1;
        if (m_cnt >= DB) accept(); else m_st = 1;
      end
      1: if (kind == 2) m_cnt = 1;
        else if (kind == 0) m_st = 0;
        else begin
          if (code != m_cand) begin m_cand = code; m_cnt = 1; end
          else m_cnt++;
          if (m_cnt >= DB) accept();
        end
      2: if (kind == 0) begin
        m_cnt = 1;
        if (m_cnt >= DB) begin m_st = 0; e_held = 0; end
        else m_st = 3;
      end
      default: if (kind != 0) m_st = 2;
        else begin
          m_cnt++;
          if (m_cnt >= DB) begin m_st = 0; e_held = 0; end
        end
    endcase
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_s1 = 4'hF; m_s2 = 4'hF;
      m_div = 0; m_col = 0; m_hits = 0; m_code = 0;
      m_st = 0; m_cnt = 0; m_cand = 0;
      e_key = 0; e_dig = 0; e_ds = 0; e_fs = 0; e_held = 0;
    end else begin
      e_ds = 0; e_fs = 0;
      m_rw = m_s2; m_s2 = m_s1; m_s1 = row_sense;
      if (m_div == SD - 1) begin
        for (int r = 0; r < 4; r++)
          if (!m_rw[r]) begin m_hits++; m_code = KM[r*4+m_col]; end
        if (m_col == 3) begin
          if (m_hits == 0) debounce(0, 0);
          else if (m_hits == 1) debounce(1, m_code);
          else debounce(2, 0);
          m_hits = 0;
        end
        m_div = 0;
        m_col = (m_col + 1) % 4;
      end else begin
        m_div++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  logic [3:0] e_col;
  always @(negedge CLK) begin
    e_col = 4'hF;
    e_col[m_col] = 1'b0;
    chk("col_drive", int'(col_drive), int'(e_col));
    chk("keycode", int'(keycode), e_key);
    chk("digit", int'(digit), e_dig);
    chk("digit_strobe", int'(digit_strobe), int'(e_ds));
    chk("fn_strobe", int'(fn_strobe), int'(e_fs));
    chk("key_held", int'(key_held), int'(e_held));
    n_ds += int'(digit_strobe);
    n_fs += int'(fn_strobe);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic align();
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!(m_col == 0 && m_div == 0) && k < 100);
    if (k >= 100) chk("align_timeout", 0, 1);
  endtask

  int ds0, fs0;

  initial begin
    cycles(3);
    chk("rst_col", int'(col_drive), 4'b1110);
    chk("rst_held", int'(key_held), 0);
    @(negedge CLK); #2 RST = 1'b1;
    cycles(20);

    // 1: hold '5'
    ds0 = n_ds;
    align(); pressed = 16'h0020;
    repeat (32) @(posedge CLK);
    @(negedge CLK);
    chk("t1_strobe", int'(digit_strobe), 1);
    chk("t1_digit", int'(digit), 5);
    chk("t1_keycode", int'(keycode), 5);
    cycles(60);
    chk("t1_count", n_ds - ds0, 1);
    chk("t1_held", int'(key_held), 1);
    align(); pressed = 16'h0;
    cycles(48);
    chk("t1_released", int'(key_held), 0);

    // 2: bounce '7'
    ds0 = n_ds;
    align();
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? 16'h0100 : 16'h0;
      cycles(5);
    end
    pressed = 16'h0;
    cycles(48);
    chk("t2_count", n_ds - ds0, 0);
    chk("t2_digit", int'(digit), 5);

    // 3: '1'+'2' together, then release '2'
    ds0 = n_ds;
    align(); pressed = 16'h0003;
    cycles(48);
    chk("t3_multi", n_ds - ds0, 0);
    align(); pressed = 16'h0001;
    cycles(40);
    chk("t3_count", n_ds - ds0, 1);
    chk("t3_digit", int'(digit), 1);
    pressed = 16'h0; cycles(48);

    // 4: '*'
    ds0 = n_ds; fs0 = n_fs;
    align(); pressed = 16'h1000;
    cycles(40);
    chk("t4_fn", n_fs - fs0, 1);
    chk("t4_ds", n_ds - ds0, 0);
    chk("t4_keycode", int'(keycode), 14);
    chk("t4_digit", int'(digit), 1);
    pressed = 16'h0; cycles(48);

    // 5: '3', short gap, long gap
    ds0 = n_ds;
    align(); pressed = 16'h0004;
    cycles(40);
    align(); pressed = 16'h0;
    cycles(16); pressed = 16'h0004;
    cycles(48);
    chk("t5_short", n_ds - ds0, 1);
    align(); pressed = 16'h0;
    cycles(48);
    align(); pressed = 16'h0004;
    cycles(40);
    chk("t5_long", n_ds - ds0, 2);
    chk("t5_digit", int'(digit), 3);
    pressed = 16'h0; cycles(48);

    // 6: reset mid-press of '9'
    align(); pressed = 16'h0400;
    cycles(20);
    #2 RST = 1'b0;
    cycles(3);
    chk("t6_col", int'(col_drive), 4'b1110);
    chk("t6_digit", int'(digit), 0);
    chk("t6_keycode", int'(keycode), 0);
    chk("t6_held", int'(key_held), 0);
    ds0 = n_ds;
    @(negedge CLK); #2 RST = 1'b1;
    repeat (32) @(posedge CLK);
    @(negedge CLK);
    chk("t6_strobe", int'(digit_strobe), 1);
    chk("t6_digit9", int'(digit), 9);
    cycles(48);
    chk("t6_count", n_ds - ds0, 1);
    pressed = 16'h0; cycles(48);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
